// File: rtl/ap_array_seq.sv
// Bit-serial associative-processing array: ROWS x {A, B, C} with a compare/write
// sequencer that evaluates logical and arithmetic ops in all enabled rows at once.
module ap_array_seq #(
    parameter int WORD_SIZE = 8,
    parameter int ROWS      = 16,
    parameter int AW        = $clog2(ROWS)
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [AW-1:0]        addr_in,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [1:0]           sel_col,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 ap_start,
    input  logic [2:0]           cmd,
    input  logic [ROWS-1:0]      row_en,
    input  logic                 irq_clr,
    output logic [WORD_SIZE:0]   data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 ap_state_irq,
    output logic                 err
);

    localparam int W  = WORD_SIZE;
    localparam int BW = (W > 2) ? $clog2(W) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] OP_OR  = 3'd0;
    localparam logic [2:0] OP_XOR = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;

    logic [W-1:0] a_q [ROWS];
    logic [W-1:0] b_q [ROWS];
    logic [W:0]   c_q [ROWS];

    logic [2:0]      state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [ROWS-1:0] en_q, en_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [2:0]      pass_q, pass_d;
    logic [ROWS-1:0] tag_q, tag_d;
    logic [ROWS-1:0] cr_snap_q, cr_snap_d;
    logic [ROWS-1:0] cr_next_q, cr_next_d;
    logic            err_q, err_d;
    logic            irq_q, irq_d;
    logic [W:0]      data_out_q;

    logic       arith;
    logic       last_pass;
    logic [1:0] lut_w;

    // Returns {carry/borrow out, result bit} for one input combination.
    function automatic logic [1:0] lut(input logic [2:0] op, input logic a,
                                       input logic b, input logic c);
        case (op)
            OP_OR:   lut = {1'b0, a | b};
            OP_XOR:  lut = {1'b0, a ^ b};
            OP_AND:  lut = {1'b0, a & b};
            OP_NOT:  lut = {1'b0, ~a};
            OP_ADD:  lut = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
            OP_SUB:  lut = {(~a & b) | (~a & c) | (b & c), a ^ b ^ c};
            default: lut = 2'b00;
        endcase
    endfunction

    // Tagged rows match the pass keys, so the LUT is driven by the keys themselves.
    assign arith     = (cmd_q == OP_ADD) || (cmd_q == OP_SUB);
    assign last_pass = arith ? (pass_q == 3'd7) : (pass_q == 3'd3);
    assign lut_w     = lut(cmd_q, pass_q[0], pass_q[1], pass_q[2]);

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            tag_d[r] = en_q[r]
                     & (a_q[r][bit_q] == pass_q[0])
                     & (b_q[r][bit_q] == pass_q[1])
                     & (!arith || (cr_snap_q[r] == pass_q[2]));
        end
    end

    always_comb begin
        cr_next_d = cr_next_q;
        if (state_q == S_WRITE) begin
            for (int r = 0; r < ROWS; r++) begin
                if (tag_q[r]) cr_next_d[r] = lut_w[1];
            end
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d   = state_q;
        cmd_d     = cmd_q;
        en_d      = en_q;
        bit_d     = bit_q;
        pass_d    = pass_q;
        cr_snap_d = cr_snap_q;
        err_d     = err_q;
        irq_d     = irq_q;
        if (irq_clr) irq_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    cmd_d = cmd;
                    if (cmd <= OP_SUB) begin
                        en_d    = row_en;
                        err_d   = 1'b0;
                        irq_d   = 1'b0;
                        state_d = S_INIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_INIT: begin
                cr_snap_d = '0;
                bit_d     = '0;
                pass_d    = '0;
                state_d   = S_COMPARE;
            end
            S_COMPARE: state_d = S_WRITE;
            S_WRITE: begin
                if (last_pass) begin
                    cr_snap_d = cr_next_d;
                    pass_d    = '0;
                    if (bit_q == BW'(W - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = S_COMPARE;
                    end
                end else begin
                    pass_d  = pass_q + 3'd1;
                    state_d = S_COMPARE;
                end
            end
            S_DONE: begin
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            en_q       <= '0;
            bit_q      <= '0;
            pass_q     <= '0;
            tag_q      <= '0;
            cr_snap_q  <= '0;
            cr_next_q  <= '0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            en_q      <= en_d;
            bit_q     <= bit_d;
            pass_q    <= pass_d;
            tag_q     <= tag_d;
            cr_snap_q <= cr_snap_d;
            cr_next_q <= cr_next_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            if (read_en) begin
                case (sel_col)
                    2'd0:    data_out_q <= {1'b0, a_q[addr_in]};
                    2'd1:    data_out_q <= {1'b0, b_q[addr_in]};
                    2'd2:    data_out_q <= c_q[addr_in];
                    default: data_out_q <= '0;
                endcase
            end
        end
    end

    // NOTE: the array is storage, not control state, so it is deliberately not reset.
    always_ff @(posedge CLK100MHZ) begin
        for (int r = 0; r < ROWS; r++) begin
            if (state_q == S_IDLE && write_en && addr_in == AW'(r)) begin
                case (sel_col)
                    2'd0:    a_q[r] <= data_in;
                    2'd1:    b_q[r] <= data_in;
                    2'd2:    c_q[r] <= {1'b0, data_in};
                    default: ;
                endcase
            end
            if (state_q == S_INIT && en_q[r]) c_q[r] <= '0;
            if (state_q == S_WRITE && tag_q[r]) c_q[r][bit_q] <= lut_w[0];
            if (state_q == S_DONE && arith && en_q[r]) c_q[r][W] <= cr_snap_q[r];
        end
    end

    assign data_out     = data_out_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign ap_state_irq = irq_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ap_array_seq.sv
// Randomised scoreboard bench for ap_array_seq (ROWS=4, WORD_SIZE=8) against an
// arithmetic reference model of the array.
module tb_ap_array_seq;

    localparam int W = 8;
    localparam int R = 4;

    logic           CLK100MHZ = 1'b0;
    logic           rst;
    logic [1:0]     addr_in;
    logic [W-1:0]   data_in;
    logic [1:0]     sel_col;
    logic           write_en, read_en, ap_start, irq_clr;
    logic [2:0]     cmd;
    logic [R-1:0]   row_en;
    logic [W:0]     data_out;
    logic           busy, done, ap_state_irq, err;

    ap_array_seq #(.WORD_SIZE(W), .ROWS(R)) dut (
        .CLK100MHZ(CLK100MHZ), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .sel_col(sel_col), .write_en(write_en), .read_en(read_en),
        .ap_start(ap_start), .cmd(cmd), .row_en(row_en), .irq_clr(irq_clr),
        .data_out(data_out), .busy(busy), .done(done),
        .ap_state_irq(ap_state_irq), .err(err)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] a_m [R];
    logic [W-1:0] b_m [R];
    logic [W:0]   c_m [R];

    logic [W:0] rd_q [$];
    int         op_q [$];
    logic       rd_v = 1'b0;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W:0] ax, bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        case (op)
            3'd0:    ref_op = ax | bx;
            3'd1:    ref_op = ax ^ bx;
            3'd2:    ref_op = ax & bx;
            3'd3:    ref_op = {1'b0, ~a};
            3'd4:    ref_op = ax + bx;
            3'd5:    ref_op = ax - bx;
            default: ref_op = '0;
        endcase
    endfunction

    // Monitor: compares read data one cycle after each read, and busy length at each done.
    always @(posedge CLK100MHZ) rd_v <= read_en;

    always @(negedge CLK100MHZ) begin
        if (rd_v) begin
            if (rd_q.size() == 0) check("read_unexpected", 1, 0);
            else check("read_data", data_out, rd_q.pop_front());
        end
        if (rst) begin
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
            if (done) begin
                if (op_q.size() == 0) check("done_unexpected", 1, 0);
                else check("busy_len", busy_cnt, op_q.pop_front());
                busy_cnt = 0;
            end
        end
    end

    task automatic host_write(input logic [1:0] col, input int row, input logic [W-1:0] d,
                              input bit upd);
        write_en = 1'b1;
        sel_col  = col;
        addr_in  = row[1:0];
        data_in  = d;
        if (upd) begin
            case (col)
                2'd0:    a_m[row] = d;
                2'd1:    b_m[row] = d;
                2'd2:    c_m[row] = {1'b0, d};
                default: ;
            endcase
        end
        @(posedge CLK100MHZ); #1;
        write_en = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] col, input int row);
        read_en = 1'b1;
        sel_col = col;
        addr_in = row[1:0];
        case (col)
            2'd0:    rd_q.push_back({1'b0, a_m[row]});
            2'd1:    rd_q.push_back({1'b0, b_m[row]});
            2'd2:    rd_q.push_back(c_m[row]);
            default: rd_q.push_back('0);
        endcase
        @(posedge CLK100MHZ); #1;
        read_en = 1'b0;
    endtask

    task automatic read_all_c();
        for (int r = 0; r < R; r++) host_read(2'd2, r);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [R-1:0] en, input bit hold_clr,
                          input bit poke);
        int  n;
        bit  legal;
        legal = (op <= 3'd5);
        op_q.push_back(legal ? ((op >= 3'd4) ? 16 * W + 2 : 8 * W + 2) : 1);
        if (legal) begin
            for (int r = 0; r < R; r++) if (en[r]) c_m[r] = ref_op(op, a_m[r], b_m[r]);
        end
        ap_start = 1'b1;
        cmd      = op;
        row_en   = en;
        irq_clr  = hold_clr;
        @(posedge CLK100MHZ); #1;
        ap_start = 1'b0;
        if (legal) begin
            check("err_cleared", err, 0);
        end else begin
            check("err_set", err, 1);
            check("done_illegal", done, 1);
        end
        if (poke) begin
            repeat (3) @(posedge CLK100MHZ);
            #1;
            host_write(2'd0, 2, 8'h77, 1'b0);
            host_read(2'd0, 0);
        end
        n = 0;
        while (busy && n < 400) begin
            @(posedge CLK100MHZ); #1;
            n++;
        end
        irq_clr = 1'b0;
        check("op_timeout", busy, 0);
        check("irq_after_done", ap_state_irq, 1);
    endtask

    initial begin
        logic [W-1:0] ta [R];
        logic [W-1:0] tb [R];
        rst = 1'b1; addr_in = '0; data_in = '0; sel_col = '0; write_en = 0; read_en = 0;
        ap_start = 0; irq_clr = 0; cmd = '0; row_en = '0;
        repeat (3) @(posedge CLK100MHZ);
        #1 rst = 1'b0;
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_irq", ap_state_irq, 0);
        check("rst_err", err, 0);

        // XOR across all rows
        ta = '{8'hF0, 8'h0F, 8'hAA, 8'h55};
        tb = '{8'h3C, 8'h3C, 8'hFF, 8'h00};
        for (int r = 0; r < R; r++) begin
            host_write(2'd0, r, ta[r], 1'b1);
            host_write(2'd1, r, tb[r], 1'b1);
        end
        run_op(3'd1, 4'hF, 1'b0, 1'b0);
        check("xor_row0_const", c_m[0], 9'h0CC);
        read_all_c();
        irq_clr = 1'b1;
        @(posedge CLK100MHZ); #1;
        irq_clr = 1'b0;
        check("irq_cleared", ap_state_irq, 0);

        // ADD: carries out of the top bit; rows 1 and 3 end at 0x1AB
        ta = '{8'd200, 8'hFF, 8'd255, 8'hFF};
        tb = '{8'd100, 8'hAC, 8'd1,   8'hAC};
        for (int r = 0; r < R; r++) begin
            host_write(2'd0, r, ta[r], 1'b1);
            host_write(2'd1, r, tb[r], 1'b1);
        end
        run_op(3'd4, 4'hF, 1'b0, 1'b0);
        check("add_row2_const", c_m[2], 9'h100);
        read_all_c();

        // AND on rows 0 and 2 only
        run_op(3'd2, 4'b0101, 1'b0, 1'b0);
        read_all_c();

        // SUB with borrow and equal operands; write during busy is dropped
        host_write(2'd0, 0, 8'd5, 1'b1); host_write(2'd1, 0, 8'd7, 1'b1);
        host_write(2'd0, 1, 8'd9, 1'b1); host_write(2'd1, 1, 8'd9, 1'b1);
        run_op(3'd5, 4'b0011, 1'b1, 1'b1);
        check("sub_row0_const", c_m[0], 9'h1FE);
        read_all_c();
        host_read(2'd0, 2);
        host_read(2'd3, 1);

        // Illegal command leaves array untouched; next legal start clears err
        run_op(3'd6, 4'hF, 1'b0, 1'b0);
        check("err_sticky", err, 1);
        read_all_c();
        run_op(3'd3, 4'b1000, 1'b0, 1'b0);
        read_all_c();

        // Randomised operations
        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < R; r++) begin
                host_write(2'd0, r, W'($urandom), 1'b1);
                host_write(2'd1, r, W'($urandom), 1'b1);
                host_write(2'd2, r, W'($urandom), 1'b1);
            end
            run_op(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            read_all_c();
            host_read(2'd1, int'($urandom_range(0, R - 1)));
        end

        // Reset in the middle of an ADD
        ap_start = 1'b1; cmd = 3'd4; row_en = 4'hF;
        @(posedge CLK100MHZ); #1;
        ap_start = 1'b0;
        repeat (19) @(posedge CLK100MHZ);
        #1 rst = 1'b1;
        @(posedge CLK100MHZ); #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_irq", ap_state_irq, 0);
        rst = 1'b0;
        for (int r = 0; r < R; r++) host_write(2'd2, r, W'(8'h10 + r), 1'b1);
        read_all_c();
        host_read(2'd0, 3);

        repeat (3) @(negedge CLK100MHZ);
        check("reads_drained", rd_q.size(), 0);
        check("ops_drained", op_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
